// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer between the UART receiver and the peripherals
//   register file. A 3-state ingest FSM takes each pending UART byte and
//   acknowledges it with a one-cycle rx_ready_clear pulse. Accepted bytes go
//   into a first-word-fall-through FIFO that the CPU drains through pop.
//
// Ports:
//   raw_clk         in   single clock for all state
//   reset           in   asynchronous, active-high reset
//   rx_data[7:0]    in   byte from UART receiver, valid while rx_ready=1
//   rx_ready        in   UART has a byte pending (level, held until acked)
//   rx_ready_clear  out  one-cycle acknowledge pulse to the UART (registered)
//   pop             in   remove head entry (one-cycle strobe)
//   data_out[7:0]   out  head byte, 8'h00 when empty
//   not_empty       out  FIFO holds at least one byte
//   full            out  count == DEPTH
//   count           out  number of stored bytes, 0..DEPTH
//   overflow        out  sticky: a received byte was dropped while full
//   overflow_clear  in   clears overflow (a same-cycle overflow event wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic                  rx_ready_clear,
    input  logic                  pop,
    output logic [7:0]            data_out,
    output logic                  not_empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            mem_q [DEPTH];

    logic push_s;
    logic pop_s;
    logic wr_en_s;
    logic full_s;
    logic empty_s;

    assign full_s  = (count_q == CNT_DEPTH);
    assign empty_s = (count_q == CNT_ZERO);

    // A byte is taken exactly once, on the IDLE cycle where rx_ready is seen high.
    assign push_s  = (state_q == ST_IDLE) && rx_ready;
    assign pop_s   = pop && !empty_s;
    // When full, a write is only allowed if a pop frees the head slot this same cycle.
    assign wr_en_s = push_s && (!full_s || pop_s);

    // Ingest FSM next state and acknowledge pulse generation.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // Wait for the UART to drop rx_ready so a slow deassert is not a second byte.
                if (!rx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer, occupancy and sticky overflow next-state logic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_en_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !wr_en_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // Setting has priority over clearing so a drop is never lost.
        if (push_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge raw_clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_ready_clear = ack_q;
    assign data_out       = empty_s ? 8'h00 : mem_q[rd_ptr_q];
    assign not_empty      = !empty_s;
    assign full           = full_s;
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the peripherals register file. It drains each byte from the UART as soon as rx_ready rises and acknowledges it with a one-cycle rx_ready_clear pulse. Bytes are held in a first-word-fall-through FIFO, so the CPU can fall behind by up to DEPTH bytes without losing data. The peripherals block reads the head byte, pops on register read, and reads level, full and overflow status.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 8 bits (16 default).

Ports:
raw_clk  input  1  single clock for all state
reset  input  1  asynchronous, active-high reset
rx_data  input  8  byte from UART receiver, valid while rx_ready=1
rx_ready  input  1  UART has a byte pending; level, held until acknowledged
rx_ready_clear  output  1  one-cycle acknowledge pulse to UART
pop  input  1  remove head entry; one-cycle strobe from register read
data_out  output  8  head byte (FWFT); 8'h00 when empty
not_empty  output  1  FIFO holds at least one byte
full  output  1  count == DEPTH
count  output  DEPTH_LOG2+1  current number of stored bytes, 0..DEPTH
overflow  output  1  sticky: a received byte was dropped because FIFO was full
overflow_clear  input  1  clears overflow

Behaviour:
- Reset (async assert, release synchronous to raw_clk):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, rx_ready_clear=0, FSM=IDLE.
  - Storage contents undefined.
  - data_out=0, not_empty=0, full=0.
- Ingest FSM, 3 states:
  - IDLE: if rx_ready=1, capture rx_data into holding reg and push it this cycle (see push rules). Assert rx_ready_clear (registered, high the next cycle) and go to ACK.
  - ACK: rx_ready_clear=1 for exactly this cycle; go to WAIT_LOW.
  - WAIT_LOW: rx_ready_clear=0; stay until rx_ready=0, then go to IDLE. This guards against the UART dropping rx_ready with latency, so one byte is never pushed twice.
  - Minimum spacing between accepted bytes is 3 cycles, far below UART byte time.
- Push rules (push = IDLE and rx_ready):
  - Not full: write at wr_ptr, wr_ptr+1 (wraps modulo DEPTH).
  - Full and pop=0: byte discarded, overflow<=1, pointers unchanged. The UART is still acknowledged.
  - Full and pop=1 same cycle: both take effect; count stays DEPTH; no overflow.
- Pop rules:
  - pop with count>0: rd_ptr+1 (wraps modulo DEPTH).
  - pop with count=0: ignored; no pointer change, no error flag.
- Count arithmetic:
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
  - Count never exceeds DEPTH or goes below 0.
- data_out:
  - Combinational read of mem[rd_ptr] when count>0, else 0.
  - A byte pushed into an empty FIFO is visible on data_out the cycle after the push.
- Status outputs:
  - not_empty = (count!=0); full = (count==DEPTH).
  - All are registered-state derived; no combinational path from rx_ready to them.
- overflow_clear:
  - Clears overflow next cycle.
  - If an overflow event occurs in the same cycle, set wins (overflow stays 1).
- Reset mid-operation (e.g. in ACK):
  - rx_ready_clear drops immediately and FSM returns to IDLE.
  - A still-high rx_ready after reset release is treated as a new byte.

Test Plan:
1. Reset, then rx_data=8'h41 with rx_ready held high until rx_ready_clear -> exactly one rx_ready_clear pulse (1 cycle wide). Next cycle: count=1, not_empty=1, data_out=8'h41.
2. Hold rx_ready high 10 cycles after ack (slow UART deassert) -> still a single push; count=1, no second rx_ready_clear.
3. Push bytes 8'h00..8'h0F, then pop 16 times -> full=1 after the 16th push. Pops return 00..0F in order. Finish with count=0, data_out=0, not_empty=0. Pointers wrap correctly on a second pass of 8'h10..8'h1F.
4. With FIFO full, push 8'hAA -> byte dropped, overflow=1, count=16, rx_ready_clear still pulses, head unchanged. Pulse overflow_clear -> overflow=0.
5. FIFO full, push 8'h55 coincident with pop -> count stays 16, overflow stays 0. After 15 more pops, data_out=8'h55.
6. Pop on empty FIFO -> count=0, no underflow. Assert reset while FSM is in ACK -> rx_ready_clear=0 immediately and count=0.
